// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: load/store size encodings,
// controller state encoding and byte-lane helpers for 32-bit words.
package dmem_pkg;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

    typedef enum logic [1:0] {ACC_BYTE, ACC_HALF, ACC_WORD} acc_t;

    typedef struct packed {
        acc_t acc;
        logic is_unsigned;
    } size_dec_t;

    // Unlisted encodings (011, 110, 111) fall through to a full-word access.
    function automatic size_dec_t decode_size(input logic [2:0] size_ctr);
        size_dec_t d;
        case (size_ctr)
            SIZE_B:  d = '{acc: ACC_BYTE, is_unsigned: 1'b0};
            SIZE_H:  d = '{acc: ACC_HALF, is_unsigned: 1'b0};
            SIZE_BU: d = '{acc: ACC_BYTE, is_unsigned: 1'b1};
            SIZE_HU: d = '{acc: ACC_HALF, is_unsigned: 1'b1};
            default: d = '{acc: ACC_WORD, is_unsigned: 1'b0};
        endcase
        return d;
    endfunction

    function automatic logic is_misaligned(input acc_t acc, input logic [1:0] lo);
        case (acc)
            ACC_HALF: return lo[0];
            ACC_WORD: return lo != 2'b00;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input acc_t acc, input logic [1:0] lo);
        case (acc)
            ACC_BYTE: return 4'b0001 << lo;
            ACC_HALF: return 4'b0011 << lo;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] align_store(input logic [31:0] data, input logic [1:0] lo);
        return data << {lo, 3'b000};
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input size_dec_t dec,
                                                 input logic [1:0] lo);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (dec.acc)
            ACC_BYTE: return dec.is_unsigned ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            ACC_HALF: return dec.is_unsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:  return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-store write buffer: a power-of-two FIFO with free-running pointers
// and an explicit occupancy count that separates full from empty.
module dmem_wbuf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [WIDTH-1:0]        head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (cnt == (PTR_W + 1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; validity comes from the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_controller.sv
// Data-memory controller: posts aligned stores into a write buffer drained to a
// LATENCY-cycle RAM, and serves loads only once the buffer has fully drained.
module dmem_controller
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2,
    parameter int WB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            size_ctr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  misaligned,
    output logic                  wb_empty
);
    localparam int WORD_AW = ADDR_WIDTH - 2;
    localparam int WORDS   = 1 << WORD_AW;
    localparam int CNT_W   = $clog2(WB_DEPTH) + 1;
    localparam logic [3:0] DRAIN_LAST = 4'(LATENCY - 1);
    localparam logic [3:0] READ_LAST  = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef struct packed {
        logic [WORD_AW-1:0]    word_addr;
        logic [3:0]            be;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    state_t     state, state_nxt;
    logic [3:0] lat_cnt, lat_cnt_nxt;
    logic       ready_en;

    size_dec_t  req_dec;
    logic [1:0] req_lo;
    logic       req_mis;
    logic       store_ok, load_ok, accept, push, load_acc, drain_fire, commit;

    wb_entry_t        push_entry, head;
    logic             wb_full, fifo_empty;
    logic [CNT_W-1:0] wb_count;

    logic [WORD_AW-1:0] ld_word_q, rd_word;
    logic [1:0]         ld_lo_q, rd_lo;
    size_dec_t          ld_dec_q, rd_dec;
    logic               ld_mis_q, rd_mis;

    logic [DATA_WIDTH-1:0] ram [WORDS];

    assign req_lo  = addr[1:0];
    assign req_dec = decode_size(size_ctr);
    assign req_mis = is_misaligned(req_dec.acc, req_lo);

    // ready_en holds requests off until the first edge after reset releases.
    assign store_ok   = rst_n && ready_en && !wb_full && (state == IDLE || state == DRAIN);
    assign load_ok    = rst_n && ready_en && (state == IDLE) && fifo_empty;
    assign req_ready  = req_write ? store_ok : load_ok;
    assign accept     = req_valid && req_ready;
    assign push       = accept && req_write && !req_mis;
    assign load_acc   = accept && !req_write;
    assign misaligned = accept && req_mis;
    assign drain_fire = (state == DRAIN) && (lat_cnt == DRAIN_LAST);
    assign commit     = drain_fire && rst_n;
    assign wb_empty   = fifo_empty && (state != DRAIN);
    assign read_valid = (state == RESP);

    assign push_entry = '{word_addr: addr[ADDR_WIDTH-1:2],
                          be:        byte_enables(req_dec.acc, req_lo),
                          data:      align_store(write_data, req_lo)};

    dmem_wbuf #(
        .DEPTH (WB_DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_wbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (drain_fire),
        .full      (wb_full),
        .empty     (fifo_empty),
        .count     (wb_count),
        .head      (head)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        case (state)
            IDLE: begin
                if (load_acc) begin
                    state_nxt   = (LATENCY == 1) ? RESP : READ;
                    lat_cnt_nxt = '0;
                end else if (!fifo_empty) begin
                    state_nxt   = DRAIN;
                    lat_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                if (drain_fire) begin
                    lat_cnt_nxt = '0;
                    if (wb_count == CNT_W'(1) && !push) state_nxt = IDLE;
                end else begin
                    lat_cnt_nxt = lat_cnt + 4'd1;
                end
            end
            READ: begin
                if (lat_cnt == READ_LAST) state_nxt = RESP;
                else                      lat_cnt_nxt = lat_cnt + 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the RAM is read on the accepting edge, before the load is latched.
    assign rd_word = (state == IDLE) ? addr[ADDR_WIDTH-1:2] : ld_word_q;
    assign rd_lo   = (state == IDLE) ? req_lo  : ld_lo_q;
    assign rd_dec  = (state == IDLE) ? req_dec : ld_dec_q;
    assign rd_mis  = (state == IDLE) ? req_mis : ld_mis_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            ready_en  <= 1'b0;
            read_data <= '0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_cnt_nxt;
            ready_en <= 1'b1;
            if (state_nxt == RESP)
                read_data <= rd_mis ? '0 : extract_load(ram[rd_word], rd_dec, rd_lo);
        end
    end

    always_ff @(posedge clk) begin
        if (load_acc) begin
            ld_word_q <= addr[ADDR_WIDTH-1:2];
            ld_lo_q   <= req_lo;
            ld_dec_q  <= req_dec;
            ld_mis_q  <= req_mis;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++)
                if (head.be[b]) ram[head.word_addr][8*b +: 8] <= head.data[8*b +: 8];
        end
    end

endmodule
